// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared fetch packet, fetch FSM state and address helper
//
// Purpose : types shared by the fetch PC generator and its packet buffer.
// Contents: XLEN/ILEN widths, fetch_pkt_t, fetch_state_t, align_word().
package rv32i_types;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no request outstanding
    ST_BUSY   = 2'd1,  // request outstanding, response will be kept
    ST_SQUASH = 2'd2   // request outstanding, response will be dropped
  } fetch_state_t;

  // BTB targets may carry junk in the byte-offset bits; fetch is word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - fetch bus: imem, BTB, execute redirect and decode handshake
//
// Purpose: bundles every non-clock signal of fetch_pc_gen.
// Modports:
//   master - the fetch unit (drives imem_addr/imem_read, btb_predict_pc, if_* packet)
//   slave  - the environment (imem, BTB, execute stage, decode)
interface fetch_pc_gen_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_read;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_resp;

  logic [ADDR_WIDTH-1:0]  btb_predict_pc;
  logic [ADDR_WIDTH-1:0]  btb_predicted_pc;
  logic                   btb_prediction;

  logic                   ex_redirect;
  logic [ADDR_WIDTH-1:0]  ex_redirect_pc;

  logic                   if_valid;
  logic                   if_ready;
  logic [ADDR_WIDTH-1:0]  if_pc;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic                   if_pred_taken;
  logic [ADDR_WIDTH-1:0]  if_pred_target;

  modport master (
    output imem_addr, imem_read, btb_predict_pc,
    output if_valid, if_pc, if_instr, if_pred_taken, if_pred_target,
    input  imem_rdata, imem_resp, btb_predicted_pc, btb_prediction,
    input  ex_redirect, ex_redirect_pc, if_ready
  );

  modport slave (
    input  imem_addr, imem_read, btb_predict_pc,
    input  if_valid, if_pc, if_instr, if_pred_taken, if_pred_target,
    output imem_rdata, imem_resp, btb_predicted_pc, btb_prediction,
    output ex_redirect, ex_redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_pc_gen_buf.sv
// rtl/fetch_pc_gen_buf.sv - 2-entry FIFO of fetch packets with flush
//
// Purpose: holds fetched packets until decode accepts them.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_pkt  write a packet at the tail
//   pop             remove the head packet (ignored when empty)
//   flush           drop all entries; wins over push and pop
//   head            packet at the head (valid when !empty)
//   count/full/empty occupancy
module fetch_buf
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output fetch_pkt_t head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  fetch_pkt_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       pop_ok;

  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd2);
  assign pop_ok = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count gates everything that reads it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_pkt;
  end

  // The fetch FSM never lets buffered + outstanding exceed two entries.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !pop_ok));

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch-stage next-PC generator with BTB lookup and packet buffer
//
// Purpose: owns the fetch PC, issues one imem read at a time, picks the next PC
//   from the BTB or PC+4, squashes in-flight reads on execute redirects and hands
//   {pc, instr, prediction} packets to decode through a 2-entry buffer.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  fetch_pc_gen_if.master: imem_*, btb_*, ex_redirect*, if_* handshake
module fetch_pc_gen
  import rv32i_types::*;
#(
  parameter int unsigned           ADDR_WIDTH  = XLEN,
  parameter int unsigned           INSTR_WIDTH = ILEN,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h6000_0000
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_gen_if.master bus
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [ADDR_WIDTH-1:0] npc;
  logic [INSTR_WIDTH-1:0] rdata;

  fetch_pkt_t push_pkt;
  fetch_pkt_t head;
  logic [1:0] buf_count;
  logic       buf_full;
  logic       buf_empty;
  logic       push;
  logic       pop;

  assign rdata = bus.imem_rdata;
  assign pop   = bus.if_valid && bus.if_ready;
  // A redirect in the response cycle drops the data; the buffer is flushed anyway.
  assign push  = (state == ST_BUSY) && bus.imem_resp && !bus.ex_redirect;
  assign npc   = bus.btb_prediction ? align_word(bus.btb_predicted_pc)
                                    : req_addr_q + ADDR_WIDTH'(4);

  always_comb begin
    push_pkt             = '0;
    push_pkt.pc          = req_addr_q;
    push_pkt.instr       = rdata;
    push_pkt.pred_taken  = bus.btb_prediction;
    push_pkt.pred_target = bus.btb_predicted_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else if (bus.ex_redirect) begin
      pc_q <= bus.ex_redirect_pc;
      // An outstanding read must still complete; its data is discarded.
      case (state)
        ST_BUSY, ST_SQUASH: state <= bus.imem_resp ? ST_IDLE : ST_SQUASH;
        default:            state <= ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          // One free slot is enough: the response lands after the request.
          if (!buf_full) begin
            req_addr_q <= pc_q;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.imem_resp) begin
            pc_q <= npc;
            // Issue back-to-back only if the buffer will still have room
            // for this read's response after the current push.
            if (buf_count == 2'd0 || pop) begin
              req_addr_q <= npc;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_SQUASH: begin
          if (bus.imem_resp) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_pkt (push_pkt),
    .pop      (pop),
    .flush    (bus.ex_redirect),
    .head     (head),
    .count    (buf_count),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign bus.imem_read      = (state != ST_IDLE);
  assign bus.imem_addr      = req_addr_q;
  assign bus.btb_predict_pc = req_addr_q;
  assign bus.if_valid       = !buf_empty;
  assign bus.if_pc          = head.pc;
  assign bus.if_instr       = head.instr;
  assign bus.if_pred_taken  = head.pred_taken;
  assign bus.if_pred_target = head.pred_target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - self-checking bench for fetch_pc_gen
module tb_fetch_pc_gen;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h6000_0000;

  logic clk = 1'b0;
  logic rst;

  fetch_pc_gen_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_pc_gen #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- environment: BTB and instruction memory ----------------
  int          btb_mode = 0;  // 0 none, 1 single entry, 2 hashed
  logic [31:0] btb_src  = 32'h0;
  logic [31:0] btb_tgt  = 32'h0;
  int          delay_min = 0;
  int          delay_max = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic btb_hit_f(input int mode, input logic [31:0] src, input logic [31:0] a);
    case (mode)
      1:       return a == src;
      2:       return a[5:2] == 4'hB;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] btb_tgt_f(input int mode, input logic [31:0] tgt, input logic [31:0] a);
    if (mode == 1) return tgt;
    return (a ^ 32'h0000_2000) + {30'd0, a[7:6]};
  endfunction

  always_comb begin
    bus.btb_prediction   = btb_hit_f(btb_mode, btb_src, bus.btb_predict_pc);
    bus.btb_predicted_pc = btb_tgt_f(btb_mode, btb_tgt, bus.btb_predict_pc);
  end

  bit pending;
  int wait_cnt;
  always @(negedge clk) begin
    if (rst) begin
      pending        = 1'b0;
      bus.imem_resp  = 1'b0;
      bus.imem_rdata = 32'h0;
    end else begin
      if (bus.imem_resp) begin
        bus.imem_resp = 1'b0;
        pending       = 1'b0;
      end
      if (bus.imem_read && !pending) begin
        pending  = 1'b1;
        wait_cnt = $urandom_range(delay_min, delay_max);
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          bus.imem_resp  = 1'b1;
          bus.imem_rdata = instr_of(bus.imem_addr);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- reference model: the architectural packet stream ----------------
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    logic [31:0] t;
    if (btb_hit_f(btb_mode, btb_src, pc)) begin
      t = btb_tgt_f(btb_mode, btb_tgt, pc);
      return t & 32'hFFFF_FFFC;
    end
    return pc + 32'd4;
  endfunction

  logic [31:0] exp_pc;
  int          pops = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      exp_pc    = RESET_PC;
      prev_hold = 1'b0;
      check("rst_imem_read", {31'd0, bus.imem_read}, 32'd0);
      check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    end else begin
      if (prev_hold && bus.imem_read)
        check("addr_stable", bus.imem_addr, prev_addr);
      if (bus.ex_redirect) begin
        exp_pc = bus.ex_redirect_pc;
      end else if (bus.if_valid && bus.if_ready) begin
        check("pkt_pc", bus.if_pc, exp_pc);
        check("pkt_instr", bus.if_instr, instr_of(exp_pc));
        check("pkt_taken", {31'd0, bus.if_pred_taken},
              {31'd0, btb_hit_f(btb_mode, btb_src, exp_pc)});
        if (btb_hit_f(btb_mode, btb_src, exp_pc))
          check("pkt_target", bus.if_pred_target, btb_tgt_f(btb_mode, btb_tgt, exp_pc));
        exp_pc = next_pc(exp_pc);
        pops++;
      end
      prev_hold = bus.imem_read && !bus.imem_resp;
      prev_addr = bus.imem_addr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic restart(input int mode, input logic [31:0] src, input logic [31:0] tgt);
    rst = 1'b1;
    bus.ex_redirect = 1'b0;
    btb_mode = mode;
    btb_src  = src;
    btb_tgt  = tgt;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_fetch(input string tag, input logic [31:0] addr, input int budget);
    int n = 0;
    while (!(bus.imem_read && bus.imem_addr == addr) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, {31'd0, bus.imem_read && bus.imem_addr == addr}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    bit hit;
    rst = 1'b1;
    bus.ex_redirect    = 1'b0;
    bus.ex_redirect_pc = 32'h0;
    bus.if_ready       = 1'b1;

    // Reset values and back-to-back sequential fetch.
    cycle();
    cycle();
    check("reset_imem_addr", bus.imem_addr, RESET_PC);
    check("reset_btb_pc", bus.btb_predict_pc, RESET_PC);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("seq_imem_read", {31'd0, bus.imem_read}, 32'd1);
      check("seq_imem_addr", bus.imem_addr, RESET_PC + 32'(4 * i));
      if (i > 0) begin
        check("seq_if_valid", {31'd0, bus.if_valid}, 32'd1);
        check("seq_if_pc", bus.if_pc, RESET_PC + 32'(4 * (i - 1)));
      end
    end

    // BTB hit redirects fetch; unaligned target is aligned for fetch only.
    for (int k = 0; k < 2; k++) begin
      restart(1, 32'h6000_0004, (k == 0) ? 32'h6000_2000 : 32'h6000_2003);
      cycle();
      cycle();
      cycle();
      check("btb_next_addr", bus.imem_addr, 32'h6000_2000);
      check("btb_pkt_pc", bus.if_pc, 32'h6000_0004);
      check("btb_pkt_taken", {31'd0, bus.if_pred_taken}, 32'd1);
      check("btb_pkt_target", bus.if_pred_target, (k == 0) ? 32'h6000_2000 : 32'h6000_2003);
    end

    // Redirect while a slow read is outstanding.
    restart(0, 32'h0, 32'h0);
    delay_min = 2;
    delay_max = 2;
    wait_fetch("reach_0010", 32'h6000_0010, 40);
    bus.ex_redirect    = 1'b1;
    bus.ex_redirect_pc = 32'h6000_8000;
    cycle();
    bus.ex_redirect = 1'b0;
    check("squash_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("squash_read_held", {31'd0, bus.imem_read}, 32'd1);
    check("squash_addr_held", bus.imem_addr, 32'h6000_0010);
    wait_fetch("redirect_fetch", 32'h6000_8000, 20);

    // PC+4 wraps at the top of the address space.
    bus.ex_redirect    = 1'b1;
    bus.ex_redirect_pc = 32'hFFFF_FFFC;
    cycle();
    bus.ex_redirect = 1'b0;
    wait_fetch("wrap_fetch", 32'h0000_0000, 30);

    // Decode stall: two packets buffered, fetch stops, then drains in order.
    bus.if_ready = 1'b0;
    repeat (10) cycle();
    check("stall_imem_read", {31'd0, bus.imem_read}, 32'd0);
    check("stall_if_valid", {31'd0, bus.if_valid}, 32'd1);
    p0 = pops;
    bus.if_ready = 1'b1;
    cycle();
    check("drain_second", {31'd0, bus.if_valid}, 32'd1);
    cycle();
    check("drain_empty", {31'd0, bus.if_valid}, 32'd0);
    check("drain_count", 32'(pops - p0), 32'd2);
    check("drain_refetch", {31'd0, bus.imem_read}, 32'd1);

    // Redirect coincident with response and pop.
    delay_min = 0;
    delay_max = 0;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cycle();
      if (bus.imem_resp && bus.if_valid && !hit) begin
        hit = 1'b1;
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 32'h6000_4000;
      end
    end
    check("coinc_found", {31'd0, hit}, 32'd1);
    cycle();
    bus.ex_redirect = 1'b0;
    check("coinc_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("coinc_idle", {31'd0, bus.imem_read}, 32'd0);
    cycle();
    check("coinc_refetch_read", {31'd0, bus.imem_read}, 32'd1);
    check("coinc_refetch_addr", bus.imem_addr, 32'h6000_4000);

    // Asynchronous reset while busy.
    repeat (3) cycle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_imem_read", {31'd0, bus.imem_read}, 32'd0);
    check("arst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("arst_imem_addr", bus.imem_addr, RESET_PC);
    check("arst_btb_pc", bus.btb_predict_pc, RESET_PC);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("arst_restart_read", {31'd0, bus.imem_read}, 32'd1);
    check("arst_restart_addr", bus.imem_addr, RESET_PC);

    // Randomized traffic against the reference model.
    restart(2, 32'h0, 32'h0);
    delay_min = 0;
    delay_max = 3;
    p0 = pops;
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        bus.ex_redirect = 1'b0;
      end else begin
        bus.if_ready       = ($urandom_range(0, 3) != 0);
        bus.ex_redirect    = ($urandom_range(0, 29) == 0);
        bus.ex_redirect_pc = {16'h6000, 14'($urandom), 2'b00};
      end
    end
    bus.ex_redirect = 1'b0;
    rst = 1'b0;
    cycle();
    check("random_progress", {31'd0, (pops - p0) > 300}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
